pairwise_magnitude_comparator: RTL

Multi-cycle N-bit magnitude comparator built around the team's 2-bit greater-than slice. It latches two WIDTH-bit operands on a start pulse and walks them from the most significant 2-bit pair to the least significant pair, one pair per clock. It stops at the first unequal pair and reports gt/eq/lt with a one-cycle done pulse. It sits directly downstream of the 2-bit comparator stage, consuming its per-pair decisions to produce a full-width result.

---
 rtl/pairwise_magnitude_comparator.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pairwise_magnitude_comparator.sv
// ----------------------------------------------------------------------------
// pairwise_magnitude_comparator
//
// Multi-cycle unsigned magnitude comparator. On an accepted start the two
// operands are latched, then walked one 2-bit pair per clock from the most
// significant pair downwards. The walk stops at the first unequal pair (or
// after pair 0 when every pair matched) and reports gt/eq/lt with a one-cycle
// done pulse. Each pair decision uses the same logic as the 2-bit
// greater-than slice.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   start  in   request a comparison; sampled only while idle
//   a, b   in   WIDTH-bit operands, latched when start is accepted
//   busy   out  comparison in progress
//   done   out  one-cycle pulse, result outputs valid
//   gt     out  A > B (unsigned)
//   eq     out  A == B
//   lt     out  A < B (unsigned)
//   npairs out  pairs examined for the last result (1..WIDTH/2)
// ----------------------------------------------------------------------------
module pairwise_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [7:0]       npairs
);

    localparam int P     = WIDTH / 2;
    localparam int IDX_W = (P > 1) ? $clog2(P) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // 2-bit greater-than slice: x > y, unsigned.
    function automatic logic pair_gt(input logic [1:0] x, input logic [1:0] y);
        return (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_r, a_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic             busy_s, done_s, gt_s, eq_s, lt_s;
    logic [7:0]       npairs_s;
    logic [WIDTH-1:0] a_sh_s, b_sh_s;
    logic [1:0]       a_pair_s, b_pair_s;

    // Select the pair currently addressed by the index (shift by 2*idx).
    always_comb begin
        a_sh_s   = a_r >> {idx_r, 1'b0};
        b_sh_s   = b_r >> {idx_r, 1'b0};
        a_pair_s = a_sh_s[1:0];
        b_pair_s = b_sh_s[1:0];
    end

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        state_s  = state_r;
        a_s      = a_r;
        b_s      = b_r;
        idx_s    = idx_r;
        busy_s   = busy;
        done_s   = 1'b0;
        gt_s     = gt;
        eq_s     = eq;
        lt_s     = lt;
        npairs_s = npairs;
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_s      = a;
                    b_s      = b;
                    idx_s    = LAST_IDX;
                    gt_s     = 1'b0;
                    eq_s     = 1'b0;
                    lt_s     = 1'b0;
                    npairs_s = 8'd0;
                    busy_s   = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                npairs_s = npairs + 8'd1;
                if (pair_gt(a_pair_s, b_pair_s)) begin
                    gt_s    = 1'b1;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else if (pair_gt(b_pair_s, a_pair_s)) begin
                    lt_s    = 1'b1;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else if (idx_r == {IDX_W{1'b0}}) begin
                    eq_s    = 1'b1;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    // Pair matched, move on to the next lower pair.
                    idx_s   = idx_r - IDX_W'(1);
                    state_s = RUN;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
            npairs  <= 8'd0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            idx_r   <= idx_s;
            busy    <= busy_s;
            done    <= done_s;
            gt      <= gt_s;
            eq      <= eq_s;
            lt      <= lt_s;
            npairs  <= npairs_s;
        end
    end

endmodule
